// File: rtl/dag_pkg.sv
// Shared definitions for the data address generator.
//   DG_CLS_*  : register class codes carried in the top two bits of the
//               write/readback select ({class, index}).
//   dg_bitrev : reverses the low w bits of a value (w <= DG_MAX_W).
package dag_pkg;

    localparam logic [1:0] DG_CLS_I = 2'b00;
    localparam logic [1:0] DG_CLS_M = 2'b01;
    localparam logic [1:0] DG_CLS_L = 2'b10;
    localparam logic [1:0] DG_CLS_B = 2'b11;

    // Widest address the reversal helper supports.
    localparam int DG_MAX_W = 32;

    // Reverse all DG_MAX_W bits, then shift the reversed field back down so
    // the result holds the bit reversal of the low w bits.
    function automatic logic [DG_MAX_W-1:0] dg_bitrev(input logic [DG_MAX_W-1:0] v,
                                                      input int w);
        logic [DG_MAX_W-1:0] r;
        r = {<<{v}};
        return r >> (DG_MAX_W - w);
    endfunction

endpackage

// File: rtl/dag_circ_next.sv
// Combinational next-index logic for one address generator.
//   i_val, m_val, l_val, b_val : current index, signed modify, length, base
//   i_next                      : updated index
//   wrap                        : a circular correction was applied
// Arithmetic is done in ADDR_WIDTH+2 signed bits so that I+M and B+L never
// overflow. Only one correction by L is applied; results for |M| > L or an
// index outside [B, B+L) are whatever that single correction gives.
module dag_circ_next
    import dag_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic [ADDR_WIDTH-1:0] i_val,
    input  logic [ADDR_WIDTH-1:0] m_val,
    input  logic [ADDR_WIDTH-1:0] l_val,
    input  logic [ADDR_WIDTH-1:0] b_val,
    output logic [ADDR_WIDTH-1:0] i_next,
    output logic                  wrap
);

    localparam int EW = ADDR_WIDTH + 2;

    logic signed [EW-1:0] t;
    logic signed [EW-1:0] lo;
    logic signed [EW-1:0] len;
    logic signed [EW-1:0] hi;

    assign t   = $signed({2'b00, i_val}) + $signed({{2{m_val[ADDR_WIDTH-1]}}, m_val});
    assign lo  = $signed({2'b00, b_val});
    assign len = $signed({2'b00, l_val});
    assign hi  = lo + len;

    always_comb begin
        // Linear mode (L == 0) falls through with the truncated sum.
        i_next = t[ADDR_WIDTH-1:0];
        wrap   = 1'b0;
        if (l_val != '0) begin
            if (t >= hi) begin
                i_next = ADDR_WIDTH'(t - len);
                wrap   = 1'b1;
            end else if (t < lo) begin
                i_next = ADDR_WIDTH'(t + len);
                wrap   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dag_circ_unit.sv
// Data address generator: I/M/L/B register bank, circular next-index
// update, pre/post-modify select, optional bit-reversed output and a
// registered register readback.
//   clk, reset (async, active low)
//   ps_dg_en/iadd/madd/mdfy/brev : address generation request
//   ps_dg_wrt_en/wrt_add, bc_dt   : register write ({class, index})
//   ps_dg_rd_add, dg_bc_dt        : registered, zero-extended readback
//   dg_add, dg_add_vld, dg_wrap   : registered address output
// Handshake: dg_add_vld is a single-cycle valid with no ready; the consumer
// must take dg_add/dg_wrap on every cycle dg_add_vld is high. dg_add holds
// its last value while dg_add_vld is low; dg_wrap is low then.
module dag_circ_unit
    import dag_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_IREG   = 8,
    parameter int IDX_W      = $clog2(NUM_IREG)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ps_dg_en,
    input  logic [IDX_W-1:0]      ps_dg_iadd,
    input  logic [IDX_W-1:0]      ps_dg_madd,
    input  logic                  ps_dg_mdfy,
    input  logic                  ps_dg_brev,
    input  logic                  ps_dg_wrt_en,
    input  logic [IDX_W+1:0]      ps_dg_wrt_add,
    input  logic [IDX_W+1:0]      ps_dg_rd_add,
    input  logic [DATA_WIDTH-1:0] bc_dt,
    output logic [ADDR_WIDTH-1:0] dg_add,
    output logic                  dg_add_vld,
    output logic                  dg_wrap,
    output logic [DATA_WIDTH-1:0] dg_bc_dt
);

    logic [ADDR_WIDTH-1:0] i_reg [NUM_IREG];
    logic [ADDR_WIDTH-1:0] m_reg [NUM_IREG];
    logic [ADDR_WIDTH-1:0] l_reg [NUM_IREG];
    logic [ADDR_WIDTH-1:0] b_reg [NUM_IREG];

    logic [ADDR_WIDTH-1:0] i_next;
    logic                  wrap;
    logic [ADDR_WIDTH-1:0] sel_add;
    logic [ADDR_WIDTH-1:0] rd_val;
    logic [1:0]            wr_cls;
    logic [IDX_W-1:0]      wr_idx;
    logic [1:0]            rd_cls;
    logic [IDX_W-1:0]      rd_idx;

    assign wr_cls = ps_dg_wrt_add[IDX_W+1:IDX_W];
    assign wr_idx = ps_dg_wrt_add[IDX_W-1:0];
    assign rd_cls = ps_dg_rd_add[IDX_W+1:IDX_W];
    assign rd_idx = ps_dg_rd_add[IDX_W-1:0];

    // L and B share the I index; M has its own select.
    dag_circ_next #(.ADDR_WIDTH(ADDR_WIDTH)) u_next (
        .i_val  (i_reg[ps_dg_iadd]),
        .m_val  (m_reg[ps_dg_madd]),
        .l_val  (l_reg[ps_dg_iadd]),
        .b_val  (b_reg[ps_dg_iadd]),
        .i_next (i_next),
        .wrap   (wrap)
    );

    always_comb begin
        sel_add = ps_dg_mdfy ? i_next : i_reg[ps_dg_iadd];
        if (ps_dg_brev) begin
            sel_add = ADDR_WIDTH'(dg_bitrev(DG_MAX_W'(sel_add), ADDR_WIDTH));
        end
    end

    always_comb begin
        rd_val = '0;
        case (rd_cls)
            DG_CLS_I: rd_val = i_reg[rd_idx];
            DG_CLS_M: rd_val = m_reg[rd_idx];
            DG_CLS_L: rd_val = l_reg[rd_idx];
            DG_CLS_B: rd_val = b_reg[rd_idx];
            default:  rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_IREG; k++) begin
                i_reg[k] <= '0;
                m_reg[k] <= '0;
                l_reg[k] <= '0;
                b_reg[k] <= '0;
            end
            dg_add     <= '0;
            dg_add_vld <= 1'b0;
            dg_wrap    <= 1'b0;
            dg_bc_dt   <= '0;
        end else begin
            if (ps_dg_en) begin
                i_reg[ps_dg_iadd] <= i_next;
                dg_add            <= sel_add;
                dg_add_vld        <= 1'b1;
                dg_wrap           <= wrap;
            end else begin
                dg_add_vld <= 1'b0;
                dg_wrap    <= 1'b0;
            end
            // Placed after the update so a same-edge write to the same I wins.
            if (ps_dg_wrt_en) begin
                case (wr_cls)
                    DG_CLS_I: i_reg[wr_idx] <= bc_dt[ADDR_WIDTH-1:0];
                    DG_CLS_M: m_reg[wr_idx] <= bc_dt[ADDR_WIDTH-1:0];
                    DG_CLS_L: l_reg[wr_idx] <= bc_dt[ADDR_WIDTH-1:0];
                    DG_CLS_B: b_reg[wr_idx] <= bc_dt[ADDR_WIDTH-1:0];
                    default:  ;
                endcase
            end
            dg_bc_dt <= DATA_WIDTH'(rd_val);
        end
    end

endmodule

// File: tb/tb_dag_circ_unit.sv
// Self-checking bench for dag_circ_unit: directed scenarios followed by
// randomized traffic, checked by a scoreboard against a reference model.
module tb_dag_circ_unit;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int NI = 8;
    localparam int IW = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          ps_dg_en;
    logic [IW-1:0] ps_dg_iadd;
    logic [IW-1:0] ps_dg_madd;
    logic          ps_dg_mdfy;
    logic          ps_dg_brev;
    logic          ps_dg_wrt_en;
    logic [IW+1:0] ps_dg_wrt_add;
    logic [IW+1:0] ps_dg_rd_add;
    logic [DW-1:0] bc_dt;
    logic [AW-1:0] dg_add;
    logic          dg_add_vld;
    logic          dg_wrap;
    logic [DW-1:0] dg_bc_dt;

    dag_circ_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_IREG(NI)) dut (
        .clk           (clk),
        .reset         (reset),
        .ps_dg_en      (ps_dg_en),
        .ps_dg_iadd    (ps_dg_iadd),
        .ps_dg_madd    (ps_dg_madd),
        .ps_dg_mdfy    (ps_dg_mdfy),
        .ps_dg_brev    (ps_dg_brev),
        .ps_dg_wrt_en  (ps_dg_wrt_en),
        .ps_dg_wrt_add (ps_dg_wrt_add),
        .ps_dg_rd_add  (ps_dg_rd_add),
        .bc_dt         (bc_dt),
        .dg_add        (dg_add),
        .dg_add_vld    (dg_add_vld),
        .dg_wrap       (dg_wrap),
        .dg_bc_dt      (dg_bc_dt)
    );

    // ---------------- reference model + scoreboard ----------------
    // mdl[class][index]: class 0=I, 1=M, 2=L, 3=B
    logic [AW-1:0] mdl [4][NI];
    logic [AW:0]   exp_q [$];   // {wrap, address}
    logic [DW-1:0] rd_q  [$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < NI; i++)
                mdl[c][i] = '0;
    endtask

    // Next index straight from the arithmetic rules, using plain integers.
    task automatic model_next(input int ia, input int ma,
                              output logic [AW-1:0] nx, output bit w);
        int iv, mv, lv, bv, t;
        iv = int'(mdl[0][ia]);
        mv = int'($signed(mdl[1][ma]));
        lv = int'(mdl[2][ia]);
        bv = int'(mdl[3][ia]);
        t  = iv + mv;
        w  = 1'b0;
        if (lv != 0) begin
            if (t >= bv + lv) begin
                t = t - lv;
                w = 1'b1;
            end else if (t < bv) begin
                t = t + lv;
                w = 1'b1;
            end
        end
        nx = t[AW-1:0];
    endtask

    // ---------------- driver ----------------
    task automatic cyc(input bit en, input int ia, input int ma, input bit md, input bit br,
                       input bit we, input logic [1:0] wc, input int wi, input logic [DW-1:0] d,
                       input logic [1:0] rc, input int ri);
        logic [AW-1:0] nx;
        logic [AW-1:0] pick;
        bit            w;
        @(negedge clk);
        ps_dg_en      = en;
        ps_dg_iadd    = IW'(ia);
        ps_dg_madd    = IW'(ma);
        ps_dg_mdfy    = md;
        ps_dg_brev    = br;
        ps_dg_wrt_en  = we;
        ps_dg_wrt_add = {wc, IW'(wi)};
        ps_dg_rd_add  = {rc, IW'(ri)};
        bc_dt         = d;
        // Readback samples the register as it stood before this edge.
        rd_q.push_back(DW'(mdl[rc][ri]));
        if (en) begin
            model_next(ia, ma, nx, w);
            pick = md ? nx : mdl[0][ia];
            if (br) pick = {<<{pick}};
            exp_q.push_back({w, pick});
            mdl[0][ia] = nx;
        end
        if (we) mdl[wc][wi] = d[AW-1:0];
        @(posedge clk);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 2'd0, 0, '0, 2'd0, 0);
    endtask

    task automatic wr(input logic [1:0] c, input int i, input logic [DW-1:0] d);
        cyc(0, 0, 0, 0, 0, 1, c, i, d, c, i);
    endtask

    task automatic rd(input logic [1:0] c, input int i);
        cyc(0, 0, 0, 0, 0, 0, 2'd0, 0, '0, c, i);
    endtask

    task automatic req(input int ia, input int ma, input bit md, input bit br);
        cyc(1, ia, ma, md, br, 0, 2'd0, 0, '0, 2'd0, ia);
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        logic [AW:0] e;
        #1;
        if (reset) begin
            if (dg_add_vld) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_vld: got dg_add_vld=1 dg_add=0x%0h expected no output", dg_add);
                end else begin
                    e = exp_q.pop_front();
                    check("dg_add", 32'(dg_add), 32'(e[AW-1:0]));
                    check("dg_wrap", 32'(dg_wrap), 32'(e[AW]));
                end
            end else begin
                check("dg_wrap_idle", 32'(dg_wrap), 32'd0);
            end
            if (rd_q.size() > 0) check("dg_bc_dt", 32'(dg_bc_dt), 32'(rd_q.pop_front()));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        ps_dg_en = 0; ps_dg_iadd = '0; ps_dg_madd = '0; ps_dg_mdfy = 0; ps_dg_brev = 0;
        ps_dg_wrt_en = 0; ps_dg_wrt_add = '0; ps_dg_rd_add = '0; bc_dt = '0;
        model_clear();
        #1;
        check("rst_add", 32'(dg_add), 32'd0);
        check("rst_vld", 32'(dg_add_vld), 32'd0);
        check("rst_bc_dt", 32'(dg_bc_dt), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_add_hold", 32'(dg_add), 32'd0);
        check("rst_vld_hold", 32'(dg_add_vld), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // All registers read zero after reset.
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < NI; i++)
                rd(2'(c), i);
        #1;
        check("post_rst_add", 32'(dg_add), 32'd0);
        check("post_rst_vld", 32'(dg_add_vld), 32'd0);

        // Linear post-modify.
        wr(2'd0, 0, 16'h0010); wr(2'd1, 0, 16'd3);
        req(0, 0, 0, 0); req(0, 0, 0, 0); req(0, 0, 0, 0);
        rd(2'd0, 0);

        // Circular upward wrap, then pre-modify variant.
        wr(2'd3, 1, 16'h0100); wr(2'd2, 1, 16'd8); wr(2'd0, 1, 16'h0106); wr(2'd1, 1, 16'd3);
        req(1, 1, 0, 0); req(1, 1, 0, 0);
        rd(2'd0, 1);
        wr(2'd0, 1, 16'h0106);
        req(1, 1, 1, 0);

        // Circular downward wrap.
        wr(2'd3, 2, 16'h0200); wr(2'd2, 2, 16'd4); wr(2'd0, 2, 16'h0201); wr(2'd1, 2, 16'hFFFE);
        req(2, 2, 0, 0);
        rd(2'd0, 2);

        // Bit reverse.
        wr(2'd0, 3, 16'h0001); wr(2'd1, 3, 16'd0);
        req(3, 3, 0, 1);
        wr(2'd0, 3, 16'h0003);
        req(3, 3, 0, 1);
        rd(2'd0, 3);

        // Collision: write and update of I0 on the same edge.
        wr(2'd0, 0, 16'h0010); wr(2'd1, 0, 16'd1);
        cyc(1, 0, 0, 0, 0, 1, 2'd0, 0, 16'h0055, 2'd0, 0);
        req(0, 0, 0, 0);

        // Update uses the old L while L of the same index is written.
        wr(2'd0, 1, 16'h0106);
        cyc(1, 1, 1, 0, 0, 1, 2'd2, 1, 16'd0, 2'd2, 1);
        req(1, 1, 0, 0);

        // Reset mid-sequence: next request sees all-zero registers.
        idle();
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        req(2, 2, 1, 0);
        rd(2'd3, 1);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            logic [DW-1:0] d;
            d = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 40));
            cyc($urandom_range(0, 1) == 1, $urandom_range(0, NI-1), $urandom_range(0, NI-1),
                $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
                $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), $urandom_range(0, NI-1), d,
                2'($urandom_range(0, 3)), $urandom_range(0, NI-1));
        end

        repeat (3) idle();
        @(negedge clk);
        check("drain_addr_q", 32'(exp_q.size()), 32'd0);
        check("drain_rd_q", 32'(rd_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
